// File: rtl/painterengine_gpu_fifo_write_arbiter.sv
// Round-robin burst arbiter for the GPU FIFO write port.
// A requester is granted only when the FIFO can hold its whole declared burst.
module painterengine_gpu_fifo_write_arbiter #(
    parameter int PARAM_DATA_WIDTH = 32,
    parameter int PARAM_REQUESTERS = 4,
    parameter int PARAM_FIFO_DEPTH = 64
) (
    input  logic                                       i_wire_write_clock,
    input  logic                                       i_wire_resetn,
    input  logic [PARAM_REQUESTERS-1:0]                i_wire_request,
    input  logic [8*PARAM_REQUESTERS-1:0]              i_wire_burst_length,
    input  logic [PARAM_REQUESTERS-1:0]                i_wire_valid,
    input  logic [PARAM_DATA_WIDTH*PARAM_REQUESTERS-1:0] i_wire_data,
    output logic [PARAM_REQUESTERS-1:0]                o_wire_grant,
    output logic [PARAM_REQUESTERS-1:0]                o_wire_accept,
    input  logic                                       i_wire_fifo_full,
    input  logic [7:0]                                 i_wire_fifo_empty_count,
    output logic                                       o_wire_fifo_write,
    output logic [PARAM_DATA_WIDTH-1:0]                o_wire_fifo_data_in,
    output logic                                       o_wire_busy,
    output logic                                       o_wire_error,
    output logic                                       o_wire_abort
);

    localparam int         IDX_W   = (PARAM_REQUESTERS > 1) ? $clog2(PARAM_REQUESTERS) : 1;
    localparam logic [8:0] MAX_LEN = 9'(PARAM_FIFO_DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_CHECK, ST_BURST, ST_RELEASE} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       len_q, len_d;
    logic [7:0]       rem_q, rem_d;

    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] idx_inc;
    logic             any_accept;

    // Scan from the farthest offset down so the nearest request at/after ptr wins.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int i = PARAM_REQUESTERS - 1; i >= 0; i--) begin
            cand = IDX_W'((int'(ptr_q) + i) % PARAM_REQUESTERS);
            if (i_wire_request[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    assign idx_inc = (idx_q == IDX_W'(PARAM_REQUESTERS - 1)) ? '0 : idx_q + 1'b1;

    always_comb begin
        o_wire_grant = '0;
        if (state_q == ST_BURST) o_wire_grant[idx_q] = 1'b1;
    end

    assign o_wire_accept       = o_wire_grant & i_wire_valid & {PARAM_REQUESTERS{~i_wire_fifo_full}};
    assign any_accept          = |o_wire_accept;
    assign o_wire_fifo_write   = any_accept;
    assign o_wire_fifo_data_in = (state_q == ST_BURST)
                               ? i_wire_data[PARAM_DATA_WIDTH*idx_q +: PARAM_DATA_WIDTH]
                               : '0;
    assign o_wire_busy         = (state_q != ST_IDLE);

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        idx_d        = idx_q;
        len_d        = len_q;
        rem_d        = rem_q;
        o_wire_error = 1'b0;
        o_wire_abort = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (sel_found) begin
                    idx_d   = sel_idx;
                    len_d   = i_wire_burst_length[8*sel_idx +: 8];
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (len_q == 8'd0 || {1'b0, len_q} > MAX_LEN) begin
                    o_wire_error = 1'b1;
                    ptr_d        = idx_inc;
                    state_d      = ST_IDLE;
                end else if (!i_wire_request[idx_q]) begin
                    state_d = ST_IDLE;
                end else if (len_q <= i_wire_fifo_empty_count) begin
                    rem_d   = len_q;
                    state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                // A final accept wins over a falling request: the burst is complete.
                if (any_accept && rem_q == 8'd1) begin
                    rem_d   = 8'd0;
                    state_d = ST_RELEASE;
                end else if (!i_wire_request[idx_q]) begin
                    o_wire_abort = 1'b1;
                    rem_d        = 8'd0;
                    ptr_d        = idx_inc;
                    state_d      = ST_IDLE;
                end else if (any_accept) begin
                    rem_d = rem_q - 8'd1;
                end
            end
            ST_RELEASE: begin
                ptr_d   = idx_inc;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments and clears on async reset.
    always_ff @(posedge i_wire_write_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            len_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            rem_q   <= rem_d;
        end
    end

endmodule

// File: tb/tb_painterengine_gpu_fifo_write_arbiter.sv
// Directed self-checking bench for painterengine_gpu_fifo_write_arbiter.
// Cycle 0 of each scenario is the IDLE cycle that first sees the request.
module tb_painterengine_gpu_fifo_write_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [8*N-1:0] blen;
    logic [N-1:0]   valid;
    logic [W*N-1:0] data;
    logic [N-1:0]   grant;
    logic [N-1:0]   accept;
    logic           full;
    logic [7:0]     empty;
    logic           fwrite;
    logic [W-1:0]   fdata;
    logic           busy;
    logic           err;
    logic           abrt;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    painterengine_gpu_fifo_write_arbiter #(
        .PARAM_DATA_WIDTH(W),
        .PARAM_REQUESTERS(N),
        .PARAM_FIFO_DEPTH(64)
    ) dut (
        .i_wire_write_clock     (clk),
        .i_wire_resetn          (rst_n),
        .i_wire_request         (req),
        .i_wire_burst_length    (blen),
        .i_wire_valid           (valid),
        .i_wire_data            (data),
        .o_wire_grant           (grant),
        .o_wire_accept          (accept),
        .i_wire_fifo_full       (full),
        .i_wire_fifo_empty_count(empty),
        .o_wire_fifo_write      (fwrite),
        .o_wire_fifo_data_in    (fdata),
        .o_wire_busy            (busy),
        .o_wire_error           (err),
        .o_wire_abort           (abrt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_len(input int k, input logic [7:0] l);
        blen[8*k +: 8] = l;
    endtask

    task automatic set_data(input int k, input logic [W-1:0] d);
        data[W*k +: W] = d;
    endtask

    task automatic clear_inputs();
        req   = '0;
        blen  = '0;
        valid = '0;
        data  = '0;
        full  = 1'b0;
        empty = 8'd64;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int          writes;
        logic [N-1:0] exp_g;

        rst_n = 1'b0;
        clear_inputs();
        #2;
        check("reset_grant", grant, 0);
        check("reset_busy", busy, 0);
        check("reset_write", fwrite, 0);
        check("reset_data", fdata, 0);
        check("reset_error", err, 0);
        check("reset_abort", abrt, 0);
        tick();
        rst_n = 1'b1;

        // Single requester, L=4, request falls with the final accept.
        set_len(0, 8'd4);
        for (int c = 0; c <= 7; c++) begin
            req[0]   = (c <= 5);
            valid[0] = 1'b1;
            set_data(0, 32'h1000 + c);
            #1;
            exp_g = (c >= 2 && c <= 5) ? 4'b0001 : 4'b0000;
            check($sformatf("single_grant_c%0d", c), grant, exp_g);
            check($sformatf("single_write_c%0d", c), fwrite, |exp_g);
            if (|exp_g) check($sformatf("single_data_c%0d", c), fdata, 32'h1000 + c);
            check($sformatf("single_busy_c%0d", c), busy, (c >= 1 && c <= 6));
            check($sformatf("single_abort_c%0d", c), abrt, 0);
            tick();
        end

        // Round-robin, all four requesting, each L=2: bursts every 5 cycles.
        do_reset();
        req   = 4'hF;
        valid = 4'hF;
        for (int k = 0; k < N; k++) set_len(k, 8'd2);
        for (int c = 0; c < 25; c++) begin
            for (int k = 0; k < N; k++) set_data(k, {8'(k), 24'(c)});
            #1;
            exp_g = ((c % 5) == 2 || (c % 5) == 3) ? 4'(1 << ((c / 5) % 4)) : 4'b0000;
            check($sformatf("rr_grant_c%0d", c), grant, exp_g);
            check($sformatf("rr_accept_c%0d", c), accept, exp_g);
            if (|exp_g) check($sformatf("rr_data_c%0d", c), fdata, {8'((c / 5) % 4), 24'(c)});
            tick();
        end

        // Space wait: L=10 held in CHECK until empty_count reaches 10.
        do_reset();
        set_len(1, 8'd10);
        writes = 0;
        for (int c = 0; c <= 17; c++) begin
            req[1]   = (c <= 15);
            valid[1] = 1'b1;
            empty    = (c >= 5) ? 8'd10 : 8'd6;
            #1;
            exp_g = (c >= 6 && c <= 15) ? 4'b0010 : 4'b0000;
            check($sformatf("space_grant_c%0d", c), grant, exp_g);
            if (fwrite) writes++;
            tick();
        end
        check("space_writes", writes, 10);

        // Illegal lengths 0 and 65 from requester 2, then pointer lands on 3.
        do_reset();
        req = 4'b0100;
        set_len(2, 8'd0);
        #1;
        check("ill_err_c0", err, 0);
        tick();
        check("ill_err_c1", err, 1);
        check("ill_grant_c1", grant, 0);
        check("ill_write_c1", fwrite, 0);
        set_len(2, 8'd65);
        tick();
        check("ill_err_c2", err, 0);
        check("ill_busy_c2", busy, 0);
        tick();
        check("ill_err_c3", err, 1);
        check("ill_grant_c3", grant, 0);
        check("ill_write_c3", fwrite, 0);
        tick();
        req   = 4'b1001;
        valid = 4'hF;
        set_len(0, 8'd1);
        set_len(3, 8'd1);
        #1;
        check("ill_err_c4", err, 0);
        tick();
        check("ill_grant_c5", grant, 0);
        check("ill_busy_c5", busy, 1);
        tick();
        check("ill_next_grant", grant, 4'b1000);
        check("ill_next_write", fwrite, 1);
        req = '0;
        tick();
        check("ill_release_grant", grant, 0);
        check("ill_release_busy", busy, 1);

        // Abort with gaps: L=8, valid 1,0,1,1 then request drops.
        do_reset();
        set_len(0, 8'd8);
        set_len(1, 8'd1);
        writes = 0;
        for (int c = 0; c <= 9; c++) begin
            req[0]   = (c <= 5) || (c >= 7);
            req[1]   = (c >= 7);
            valid[0] = (c == 2 || c == 4 || c == 5);
            valid[1] = 1'b1;
            #1;
            if (c <= 6 && fwrite) writes++;
            check($sformatf("abort_pulse_c%0d", c), abrt, (c == 6));
            if (c == 3) check("abort_gap_write", fwrite, 0);
            if (c == 7) check("abort_grant_dropped", grant, 0);
            if (c == 9) check("abort_next_grant", grant, 4'b0010);
            tick();
        end
        check("abort_writes", writes, 3);

        // Full interlock: L=3, full during cycles 3 and 4.
        do_reset();
        set_len(0, 8'd3);
        valid[0] = 1'b1;
        for (int c = 0; c <= 7; c++) begin
            req[0] = (c <= 6);
            full   = (c == 3 || c == 4);
            #1;
            check($sformatf("full_write_c%0d", c), fwrite, (c == 2 || c == 5 || c == 6));
            check($sformatf("full_grant_c%0d", c), grant, (c >= 2 && c <= 6) ? 4'b0001 : 4'b0000);
            if (c == 3) check("full_accept_c3", accept, 0);
            tick();
        end

        // Asynchronous reset in the middle of a burst.
        req[0] = 1'b1;
        set_len(0, 8'd8);
        set_data(0, 32'hCAFE_F00D);
        tick();
        tick();
        #1;
        check("mid_grant_before", grant, 4'b0001);
        check("mid_write_before", fwrite, 1);
        rst_n = 1'b0;
        #1;
        check("mid_grant", grant, 0);
        check("mid_accept", accept, 0);
        check("mid_write", fwrite, 0);
        check("mid_data", fdata, 0);
        check("mid_busy", busy, 0);
        check("mid_error", err, 0);
        check("mid_abort", abrt, 0);
        tick();
        req   = '0;
        rst_n = 1'b1;
        tick();
        check("post_reset_busy", busy, 0);
        check("post_reset_grant", grant, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
